fx_div_pipe: RTL

Parametrised, fully pipelined signed fixed-point divider for the QMC/LSM datapath. It is the successor to the fixed-latency start/done divider. It adds a valid/ready handshake with full-pipeline backpressure, a configurable stage depth (quotient bits per stage), a pass-through tag, saturation on overflow, a divide-by-zero flag, and optional round-to-nearest. It sits between the regression/basis-function stages and their consumers, and sustains one divide per cycle.

---
 rtl/fx_pkg.sv | 16 +
 rtl/fx_div_stage.sv | 75 +++++++
 rtl/fx_div_pipe.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fx_pkg.sv
// Shared types, saturation constants and stage-count helper for the fx_div_pipe divider.
package fx_pkg;

    localparam int FX_W = 32;

    typedef logic signed [FX_W-1:0] fx_t;

    localparam fx_t FX_MAX = {1'b0, {(FX_W-1){1'b1}}};
    localparam fx_t FX_MIN = {1'b1, {(FX_W-1){1'b0}}};

    // Number of division stages needed to resolve nq quotient bits at bps bits per stage.
    function automatic int fx_num_stages(input int nq, input int bps);
        return (nq + bps - 1) / bps;
    endfunction

endpackage

// File: rtl/fx_div_stage.sv
// One pipeline stage of the restoring divider: resolves STAGE_BITS quotient bits and
// carries the operation's sideband (sign, divide-by-zero, tag, valid) alongside.
module fx_div_stage
    import fx_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NQ         = 48,
    parameter int STAGE_BITS = 4,
    parameter int TAG_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH:0]   in_rem,
    input  logic [WIDTH-1:0] in_den,
    input  logic [NQ-1:0]    in_dq,
    input  logic             in_sign,
    input  logic             in_dz,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [WIDTH:0]   out_rem,
    output logic [WIDTH-1:0] out_den,
    output logic [NQ-1:0]    out_dq,
    output logic             out_sign,
    output logic             out_dz,
    output logic [TAG_W-1:0] out_tag
);

    logic [WIDTH:0]   rem_s;
    logic [WIDTH+1:0] trial_s;
    logic [WIDTH+1:0] diff_s;
    logic [NQ-1:0]    dq_s;

    // dq holds unconsumed dividend bits on top and the quotient bits produced so far below.
    always_comb begin
        rem_s   = in_rem;
        dq_s    = in_dq;
        trial_s = {(WIDTH+2){1'b0}};
        diff_s  = {(WIDTH+2){1'b0}};
        for (int j = 0; j < STAGE_BITS; j++) begin
            trial_s = {rem_s, dq_s[NQ-1]};
            diff_s  = trial_s - {2'b00, in_den};
            if (diff_s[WIDTH+1]) begin
                rem_s = trial_s[WIDTH:0];
                dq_s  = {dq_s[NQ-2:0], 1'b0};
            end else begin
                rem_s = diff_s[WIDTH:0];
                dq_s  = {dq_s[NQ-2:0], 1'b1};
            end
        end
    end

    // Stage register; holds its contents whenever the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_rem   <= {(WIDTH+1){1'b0}};
            out_den   <= {WIDTH{1'b0}};
            out_dq    <= {NQ{1'b0}};
            out_sign  <= 1'b0;
            out_dz    <= 1'b0;
            out_tag   <= {TAG_W{1'b0}};
        end else if (en) begin
            out_valid <= in_valid;
            out_rem   <= rem_s;
            out_den   <= in_den;
            out_dq    <= dq_s;
            out_sign  <= in_sign;
            out_dz    <= in_dz;
            out_tag   <= in_tag;
        end
    end

endmodule

// File: rtl/fx_div_pipe.sv
// Fully pipelined signed Q-format divider with valid/ready backpressure, tag, saturation
// and divide-by-zero flag. Define FX_DIV_ROUND_EN for round-half-away-from-zero results.
module fx_div_pipe
    import fx_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int QINT           = 16,
    parameter int QFRAC          = WIDTH - QINT,
    parameter int BITS_PER_STAGE = 4,
    parameter int TAG_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_num,
    input  logic [WIDTH-1:0] in_den,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_ovf,
    output logic             out_dz
);

    localparam int N = WIDTH + QFRAC;
`ifdef FX_DIV_ROUND_EN
    localparam int NQ = N + 1;
`else
    localparam int NQ = N;
`endif
    localparam int S         = fx_num_stages(NQ, BITS_PER_STAGE);
    localparam int LAST_BITS = NQ - (S - 1) * BITS_PER_STAGE;
    localparam int MAGW      = N + 1;

    localparam logic [WIDTH-1:0] SAT_MAX = (WIDTH == FX_W) ? WIDTH'(FX_MAX) : {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = (WIDTH == FX_W) ? WIDTH'(FX_MIN) : {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [MAGW-1:0]  POS_LIM = MAGW'(SAT_MAX);
    localparam logic [MAGW-1:0]  NEG_LIM = MAGW'(SAT_MIN);

    logic             adv_s;
    logic [WIDTH-1:0] num_mag_s;
    logic [WIDTH-1:0] den_mag_s;

    logic             v0_r;
    logic             sign0_r;
    logic             dz0_r;
    logic [WIDTH-1:0] num_mag0_r;
    logic [WIDTH-1:0] den_mag0_r;
    logic [TAG_W-1:0] tag0_r;

    logic             v_a    [0:S];
    logic [WIDTH:0]   rem_a  [0:S];
    logic [WIDTH-1:0] den_a  [0:S];
    logic [NQ-1:0]    dq_a   [0:S];
    logic             sign_a [0:S];
    logic             dz_a   [0:S];
    logic [TAG_W-1:0] tag_a  [0:S];

    logic [MAGW-1:0]  mag_s;
    logic [WIDTH-1:0] q_s;
    logic             ovf_s;

    assign adv_s    = !out_valid || out_ready;
    assign in_ready = adv_s && !rst;

    // Operand magnitudes; WIDTH bits unsigned so the most negative value maps to 2^(WIDTH-1).
    always_comb begin
        if (in_num[WIDTH-1]) begin
            num_mag_s = {WIDTH{1'b0}} - in_num;
        end else begin
            num_mag_s = in_num;
        end
        if (in_den[WIDTH-1]) begin
            den_mag_s = {WIDTH{1'b0}} - in_den;
        end else begin
            den_mag_s = in_den;
        end
    end

    // Input register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            v0_r       <= 1'b0;
            sign0_r    <= 1'b0;
            dz0_r      <= 1'b0;
            num_mag0_r <= {WIDTH{1'b0}};
            den_mag0_r <= {WIDTH{1'b0}};
            tag0_r     <= {TAG_W{1'b0}};
        end else if (adv_s) begin
            v0_r       <= in_valid;
            sign0_r    <= in_num[WIDTH-1] ^ in_den[WIDTH-1];
            dz0_r      <= (in_den == {WIDTH{1'b0}});
            num_mag0_r <= num_mag_s;
            den_mag0_r <= den_mag_s;
            tag0_r     <= in_tag;
        end
    end

    assign v_a[0]    = v0_r;
    assign rem_a[0]  = {(WIDTH+1){1'b0}};
    assign den_a[0]  = den_mag0_r;
    assign dq_a[0]   = {num_mag0_r, {(NQ-WIDTH){1'b0}}};
    assign sign_a[0] = sign0_r;
    assign dz_a[0]   = dz0_r;
    assign tag_a[0]  = tag0_r;

    for (genvar i = 0; i < S; i++) begin : g_stage
        fx_div_stage #(
            .WIDTH      (WIDTH),
            .NQ         (NQ),
            .STAGE_BITS ((i == S - 1) ? LAST_BITS : BITS_PER_STAGE),
            .TAG_W      (TAG_W)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (adv_s),
            .in_valid  (v_a[i]),
            .in_rem    (rem_a[i]),
            .in_den    (den_a[i]),
            .in_dq     (dq_a[i]),
            .in_sign   (sign_a[i]),
            .in_dz     (dz_a[i]),
            .in_tag    (tag_a[i]),
            .out_valid (v_a[i+1]),
            .out_rem   (rem_a[i+1]),
            .out_den   (den_a[i+1]),
            .out_dq    (dq_a[i+1]),
            .out_sign  (sign_a[i+1]),
            .out_dz    (dz_a[i+1]),
            .out_tag   (tag_a[i+1])
        );
    end

    // Rounding, then sign, then saturation; a zero divisor overrides all of it.
    always_comb begin
`ifdef FX_DIV_ROUND_EN
        mag_s = MAGW'(dq_a[S][NQ-1:1]) + MAGW'(dq_a[S][0]);
`else
        mag_s = MAGW'(dq_a[S]);
`endif
        q_s   = {WIDTH{1'b0}};
        ovf_s = 1'b0;
        if (dz_a[S]) begin
            q_s = sign_a[S] ? SAT_MIN : SAT_MAX;
        end else if (!sign_a[S] && (mag_s > POS_LIM)) begin
            q_s   = SAT_MAX;
            ovf_s = 1'b1;
        end else if (sign_a[S] && (mag_s > NEG_LIM)) begin
            q_s   = SAT_MIN;
            ovf_s = 1'b1;
        end else if (sign_a[S]) begin
            q_s = {WIDTH{1'b0}} - mag_s[WIDTH-1:0];
        end else begin
            q_s = mag_s[WIDTH-1:0];
        end
    end

    // Output register; payload frozen while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_q     <= {WIDTH{1'b0}};
            out_tag   <= {TAG_W{1'b0}};
            out_ovf   <= 1'b0;
            out_dz    <= 1'b0;
        end else if (adv_s) begin
            out_valid <= v_a[S];
            out_q     <= q_s;
            out_tag   <= tag_a[S];
            out_ovf   <= ovf_s;
            out_dz    <= dz_a[S];
        end
    end

endmodule
